glove_locator: RTL and testbench

Per-frame glove tracker that sits directly upstream of `catch_game` and drives its glove position and grip inputs. It consumes a raster-ordered stream of per-pixel colour-match flags for two glove markers, indexed by `hcount`/`vcount`. Over each frame it accumulates a bounding box and a hit count per glove. At end of frame it publishes each glove's bounding-box midpoint, a seen flag, and a hysteretic closed/open decision, replacing the switch-driven placeholders.

---
 rtl/catch_pkg.sv | 23 ++
 rtl/glove_bbox.sv | 119 +++++++++++
 rtl/glove_locator.sv | 113 +++++++++++
 tb/tb_glove_locator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/catch_pkg.sv
// catch_pkg: shared raster geometry, frame FSM states and the glove position
// record used by glove_locator and the downstream catch_game.
package catch_pkg;

  localparam int unsigned HACTIVE = 1024;
  localparam int unsigned VACTIVE = 768;
  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } frame_state_e;

  typedef struct packed {
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          seen;
    logic          closed;
  } glove_pos_t;

endpackage

// File: rtl/glove_bbox.sv
// glove_bbox: per-glove bounding-box / hit-count accumulator with the
// end-of-frame publish rule and closed/open grip hysteresis.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_clear             restart accumulation from clear values this cycle
//   i_take              pixel is active and inside an accumulating frame
//   i_hit               colour match for this glove
//   i_hcount, i_vcount  current pixel coordinates
//   i_latch             publish the accumulated frame into o_pos
//   o_pos               registered published position/seen/closed
module glove_bbox
  import catch_pkg::HW, catch_pkg::VW, catch_pkg::glove_pos_t;
#(
  parameter int unsigned HACTIVE    = 1024,
  parameter int unsigned VACTIVE    = 768,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned CLOSE_TH   = 400,
  parameter int unsigned OPEN_TH    = 600
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_take,
  input  logic          i_hit,
  input  logic [HW-1:0] i_hcount,
  input  logic [VW-1:0] i_vcount,
  input  logic          i_latch,
  output glove_pos_t    o_pos
);

  localparam int unsigned      SW_H     = HW + 1;
  localparam int unsigned      SW_V     = VW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [HW-1:0]    XMIN_CLR = HW'(HACTIVE - 1);
  localparam logic [VW-1:0]    YMIN_CLR = VW'(VACTIVE - 1);
  localparam logic [HW-1:0]    X_RST    = HW'(HACTIVE / 2);
  localparam logic [VW-1:0]    Y_RST    = VW'(VACTIVE / 2);

  logic [HW-1:0]    r_xmin, r_xmax, w_xmin_base, w_xmax_base, w_xmin_nxt, w_xmax_nxt;
  logic [VW-1:0]    r_ymin, r_ymax, w_ymin_base, w_ymax_base, w_ymin_nxt, w_ymax_nxt;
  logic [CNT_W-1:0] r_count, w_cnt_base, w_cnt_nxt;
  logic [SW_H-1:0]  w_xsum;
  logic [SW_V-1:0]  w_ysum;
  logic             w_seen, w_closed_nxt;
  glove_pos_t       r_pos;

  // Accumulator update; a clear and a first pixel may land in the same cycle,
  // so the pixel folds into the clear values rather than the stale frame.
  always_comb begin
    w_xmin_base = r_xmin;
    w_xmax_base = r_xmax;
    w_ymin_base = r_ymin;
    w_ymax_base = r_ymax;
    w_cnt_base  = r_count;
    if (i_clear) begin
      w_xmin_base = XMIN_CLR;
      w_xmax_base = '0;
      w_ymin_base = YMIN_CLR;
      w_ymax_base = '0;
      w_cnt_base  = '0;
    end
    w_xmin_nxt = w_xmin_base;
    w_xmax_nxt = w_xmax_base;
    w_ymin_nxt = w_ymin_base;
    w_ymax_nxt = w_ymax_base;
    w_cnt_nxt  = w_cnt_base;
    if (i_take && i_hit) begin
      if (i_hcount < w_xmin_base) w_xmin_nxt = i_hcount;
      if (i_hcount > w_xmax_base) w_xmax_nxt = i_hcount;
      if (i_vcount < w_ymin_base) w_ymin_nxt = i_vcount;
      if (i_vcount > w_ymax_base) w_ymax_nxt = i_vcount;
      if (w_cnt_base != CNT_MAX) w_cnt_nxt = w_cnt_base + CNT_W'(1);
    end
  end

  // Publish decision from the frame just accumulated.
  always_comb begin
    w_seen       = 32'(r_count) >= MIN_PIXELS;
    w_xsum       = SW_H'(r_xmin) + SW_H'(r_xmax);
    w_ysum       = SW_V'(r_ymin) + SW_V'(r_ymax);
    w_closed_nxt = r_pos.closed;
    if (32'(r_count) < CLOSE_TH)     w_closed_nxt = 1'b1;
    else if (32'(r_count) > OPEN_TH) w_closed_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xmin  <= XMIN_CLR;
      r_xmax  <= '0;
      r_ymin  <= YMIN_CLR;
      r_ymax  <= '0;
      r_count <= '0;
    end else begin
      r_xmin  <= w_xmin_nxt;
      r_xmax  <= w_xmax_nxt;
      r_ymin  <= w_ymin_nxt;
      r_ymax  <= w_ymax_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  // Published record; position and grip hold while the glove is unseen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '{x: X_RST, y: Y_RST, seen: 1'b0, closed: 1'b0};
    end else if (i_latch) begin
      r_pos.seen <= w_seen;
      if (w_seen) begin
        r_pos.x      <= HW'(w_xsum >> 1);
        r_pos.y      <= VW'(w_ysum >> 1);
        r_pos.closed <= w_closed_nxt;
      end
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/glove_locator.sv
// glove_locator: per-frame tracker for two glove markers. Frames the raster
// stream, decodes the active area and publishes each glove's midpoint, seen
// flag and grip state once per frame.
// Ports:
//   vclock, reset_b            pixel clock, async active-low reset
//   hcount, vcount             raster position of the current pixel
//   hit1, hit2                 per-glove colour match at that pixel
//   glove{1,2}{x,y,seen,closed} published results (registered)
//   frame_done                 one-cycle strobe when the results update
module glove_locator
  import catch_pkg::HW, catch_pkg::VW, catch_pkg::frame_state_e,
         catch_pkg::WAIT, catch_pkg::ACCUM, catch_pkg::LATCH,
         catch_pkg::glove_pos_t;
#(
  parameter int unsigned HACTIVE    = 1024,
  parameter int unsigned VACTIVE    = 768,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned CLOSE_TH   = 400,
  parameter int unsigned OPEN_TH    = 600
) (
  input  logic          vclock,
  input  logic          reset_b,
  input  logic [HW-1:0] hcount,
  input  logic [VW-1:0] vcount,
  input  logic          hit1,
  input  logic          hit2,
  output logic [HW-1:0] glove1x,
  output logic [VW-1:0] glove1y,
  output logic          glove1seen,
  output logic          glove1closed,
  output logic [HW-1:0] glove2x,
  output logic [VW-1:0] glove2y,
  output logic          glove2seen,
  output logic          glove2closed,
  output logic          frame_done
);

  frame_state_e r_state, w_state_nxt;
  logic         w_start, w_end, w_active, w_take, w_latch;
  logic         r_frame_done;
  glove_pos_t   w_pos1, w_pos2;

  // Raster decode: frame start pixel, frame end marker, active area.
  always_comb begin
    w_start  = (hcount == '0) && (vcount == '0);
    w_end    = (hcount == '0) && (32'(vcount) == VACTIVE);
    w_active = (32'(hcount) < HACTIVE) && (32'(vcount) < VACTIVE);
  end

  always_ff @(posedge vclock or negedge reset_b) begin
    if (!reset_b) r_state <= WAIT;
    else          r_state <= w_state_nxt;
  end

  // Frame FSM; the start pixel is accumulated on the cycle it is recognised.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      WAIT: begin
        w_take = w_start & w_active;
        if (w_start) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        w_take = w_active;
        if (w_end) w_state_nxt = LATCH;
      end
      LATCH: begin
        w_latch     = 1'b1;
        w_take      = w_start & w_active;
        w_state_nxt = w_start ? ACCUM : WAIT;
      end
      default: w_state_nxt = WAIT;
    endcase
  end

  // Results load at the end of the LATCH cycle, so the strobe follows it.
  always_ff @(posedge vclock or negedge reset_b) begin
    if (!reset_b) r_frame_done <= 1'b0;
    else          r_frame_done <= w_latch;
  end

  glove_bbox #(
    .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .CNT_W(CNT_W),
    .MIN_PIXELS(MIN_PIXELS), .CLOSE_TH(CLOSE_TH), .OPEN_TH(OPEN_TH)
  ) u_glove1 (
    .clk(vclock), .rst_n(reset_b), .i_clear(w_latch), .i_take(w_take),
    .i_hit(hit1), .i_hcount(hcount), .i_vcount(vcount), .i_latch(w_latch),
    .o_pos(w_pos1)
  );

  glove_bbox #(
    .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .CNT_W(CNT_W),
    .MIN_PIXELS(MIN_PIXELS), .CLOSE_TH(CLOSE_TH), .OPEN_TH(OPEN_TH)
  ) u_glove2 (
    .clk(vclock), .rst_n(reset_b), .i_clear(w_latch), .i_take(w_take),
    .i_hit(hit2), .i_hcount(hcount), .i_vcount(vcount), .i_latch(w_latch),
    .o_pos(w_pos2)
  );

  assign glove1x      = w_pos1.x;
  assign glove1y      = w_pos1.y;
  assign glove1seen   = w_pos1.seen;
  assign glove1closed = w_pos1.closed;
  assign glove2x      = w_pos2.x;
  assign glove2y      = w_pos2.y;
  assign glove2seen   = w_pos2.seen;
  assign glove2closed = w_pos2.closed;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_glove_locator.sv
// Bench for glove_locator on a reduced raster (64x48 active, 72x50 total),
// with a second instance using a 4-bit hit counter to exercise saturation.
module tb_glove_locator;
  import catch_pkg::HW, catch_pkg::VW;

  localparam int HA = 64;
  localparam int VA = 48;
  localparam int HT = 72;
  localparam int VT = 50;

  logic          vclock = 1'b0;
  logic          reset_b;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hit1, hit2;

  logic [HW-1:0] a_g1x, a_g2x, s_g1x, s_g2x;
  logic [VW-1:0] a_g1y, a_g2y, s_g1y, s_g2y;
  logic          a_g1s, a_g2s, s_g1s, s_g2s;
  logic          a_g1c, a_g2c, s_g1c, s_g2c;
  logic          a_fd, s_fd;

  always #5 vclock = ~vclock;

  glove_locator #(.HACTIVE(HA), .VACTIVE(VA)) dut (
    .vclock(vclock), .reset_b(reset_b), .hcount(hcount), .vcount(vcount),
    .hit1(hit1), .hit2(hit2),
    .glove1x(a_g1x), .glove1y(a_g1y), .glove1seen(a_g1s), .glove1closed(a_g1c),
    .glove2x(a_g2x), .glove2y(a_g2y), .glove2seen(a_g2s), .glove2closed(a_g2c),
    .frame_done(a_fd)
  );

  glove_locator #(.HACTIVE(HA), .VACTIVE(VA), .CNT_W(4), .MIN_PIXELS(4),
                  .CLOSE_TH(10), .OPEN_TH(14)) dut_sat (
    .vclock(vclock), .reset_b(reset_b), .hcount(hcount), .vcount(vcount),
    .hit1(hit1), .hit2(hit2),
    .glove1x(s_g1x), .glove1y(s_g1y), .glove1seen(s_g1s), .glove1closed(s_g1c),
    .glove2x(s_g2x), .glove2y(s_g2y), .glove2seen(s_g2s), .glove2closed(s_g2c),
    .frame_done(s_fd)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int frame_no = 0;

  // Hit maps for the frame being driven, indexed [glove][v][h].
  bit map [2][VT][HT];

  // Reference model: per-instance parameters and published state.
  int p_cmax [2] = '{1048575, 15};
  int p_min  [2] = '{16, 4};
  int p_cls  [2] = '{400, 10};
  int p_opn  [2] = '{600, 14};
  int m_x [2][2], m_y [2][2], m_seen [2][2], m_closed [2][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int g = 0; g < 2; g++) begin
        m_x[i][g] = HA / 2; m_y[i][g] = VA / 2;
        m_seen[i][g] = 0;   m_closed[i][g] = 0;
      end
  endtask

  // Count / bounding box over the active area, then the publish rule.
  task automatic model_frame();
    for (int g = 0; g < 2; g++) begin
      int n = 0, x0 = HA, x1 = -1, y0 = VA, y1 = -1;
      for (int v = 0; v < VA; v++)
        for (int h = 0; h < HA; h++)
          if (map[g][v][h]) begin
            n++;
            if (h < x0) x0 = h;
            if (h > x1) x1 = h;
            if (v < y0) y0 = v;
            if (v > y1) y1 = v;
          end
      for (int i = 0; i < 2; i++) begin
        int c = (n > p_cmax[i]) ? p_cmax[i] : n;
        if (c >= p_min[i]) begin
          m_seen[i][g] = 1;
          m_x[i][g] = (x0 + x1) / 2;
          m_y[i][g] = (y0 + y1) / 2;
          if (c < p_cls[i])      m_closed[i][g] = 1;
          else if (c > p_opn[i]) m_closed[i][g] = 0;
        end else begin
          m_seen[i][g] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] ox, oy, os, oc;
    for (int i = 0; i < 2; i++)
      for (int g = 0; g < 2; g++) begin
        if (i == 0 && g == 0)      begin ox = 32'(a_g1x); oy = 32'(a_g1y); os = 32'(a_g1s); oc = 32'(a_g1c); end
        else if (i == 0)           begin ox = 32'(a_g2x); oy = 32'(a_g2y); os = 32'(a_g2s); oc = 32'(a_g2c); end
        else if (g == 0)           begin ox = 32'(s_g1x); oy = 32'(s_g1y); os = 32'(s_g1s); oc = 32'(s_g1c); end
        else                       begin ox = 32'(s_g2x); oy = 32'(s_g2y); os = 32'(s_g2s); oc = 32'(s_g2c); end
        check($sformatf("%s_i%0d_g%0d_x", tag, i, g + 1), ox, 32'(m_x[i][g]));
        check($sformatf("%s_i%0d_g%0d_y", tag, i, g + 1), oy, 32'(m_y[i][g]));
        check($sformatf("%s_i%0d_g%0d_seen", tag, i, g + 1), os, 32'(m_seen[i][g]));
        check($sformatf("%s_i%0d_g%0d_closed", tag, i, g + 1), oc, 32'(m_closed[i][g]));
      end
  endtask

  task automatic clr_maps();
    for (int g = 0; g < 2; g++)
      for (int v = 0; v < VT; v++)
        for (int h = 0; h < HT; h++) map[g][v][h] = 1'b0;
  endtask

  task automatic rect(input int g, input int x0, input int y0, input int w, input int ht);
    for (int v = y0; v < y0 + ht; v++)
      for (int h = x0; h < x0 + w; h++) map[g][v][h] = 1'b1;
  endtask

  // Exactly n distinct hits scattered over the active area.
  task automatic scatter(input int g, input int n);
    int placed = 0;
    while (placed < n) begin
      int h = $urandom_range(HA - 1, 0);
      int v = $urandom_range(VA - 1, 0);
      if (!map[g][v][h]) begin map[g][v][h] = 1'b1; placed++; end
    end
  endtask

  // Hits in horizontal and vertical blanking, which must never count.
  task automatic blank_noise(input int g);
    for (int k = 0; k < 30; k++) begin
      map[g][$urandom_range(VT - 1, 0)][$urandom_range(HT - 1, HA)] = 1'b1;
      map[g][$urandom_range(VT - 1, VA)][$urandom_range(HT - 1, 0)] = 1'b1;
    end
  endtask

  task automatic random_glove(input int g);
    if ($urandom_range(1, 0) == 1) begin
      int w = $urandom_range(30, 1);
      int ht = $urandom_range(30, 1);
      rect(g, $urandom_range(HA - w, 0), $urandom_range(VA - ht, 0), w, ht);
    end else begin
      scatter(g, $urandom_range(900, 0));
    end
    blank_noise(g);
  endtask

  task automatic run_rows(input int v0, input int v1,
                          output int pa, output int ia, output int ps, output int is_);
    pa = 0; ia = -1; ps = 0; is_ = -1;
    for (int v = v0; v < v1; v++)
      for (int h = 0; h < HT; h++) begin
        hcount = HW'(h);
        vcount = VW'(v);
        hit1   = map[0][v][h];
        hit2   = map[1][v][h];
        @(posedge vclock);
        #1;
        if (a_fd === 1'b1) begin pa++; ia = v * HT + h; end
        if (s_fd === 1'b1) begin ps++; is_ = v * HT + h; end
      end
  endtask

  // Full frame: strobe once, two pixels after the frame-end marker is sampled.
  task automatic run_frame(input string tag);
    int pa, ia, ps, is_;
    frame_no++;
    model_frame();
    run_rows(0, VT, pa, ia, ps, is_);
    check($sformatf("%s_f%0d_fd_pulses", tag, frame_no), 32'(pa), 32'd1);
    check($sformatf("%s_f%0d_fd_time", tag, frame_no), 32'(ia), 32'(VA * HT + 1));
    check($sformatf("%s_f%0d_sat_fd_pulses", tag, frame_no), 32'(ps), 32'd1);
    check($sformatf("%s_f%0d_sat_fd_time", tag, frame_no), 32'(is_), 32'(VA * HT + 1));
    check_outputs($sformatf("%s_f%0d", tag, frame_no));
  endtask

  initial begin
    int pa, ia, ps, is_;
    int hyst_cnt [5] = '{700, 500, 300, 500, 700};
    int hyst_cl  [5] = '{0, 0, 1, 1, 0};
    logic [31:0] sx, sy, sc;

    reset_b = 1'b0;
    hcount  = HW'(HT - 1);
    vcount  = VW'(VT - 1);
    hit1    = 1'b0;
    hit2    = 1'b0;
    model_reset();
    repeat (3) @(posedge vclock);
    #1;
    check("reset_fd", 32'(a_fd), 32'd0);
    check_outputs("reset");
    reset_b = 1'b1;
    @(posedge vclock);
    #1;

    // Single 20x20 blob for glove 1: count 400 sits on CLOSE_TH, so stays open.
    clr_maps();
    rect(0, 10, 12, 20, 20);
    blank_noise(0);
    blank_noise(1);
    run_frame("blob");
    check("blob_x", 32'(a_g1x), 32'd19);
    check("blob_y", 32'(a_g1y), 32'd21);
    check("blob_seen", 32'(a_g1s), 32'd1);
    check("blob_closed", 32'(a_g1c), 32'd0);

    // Grip hysteresis on glove 2.
    for (int k = 0; k < 5; k++) begin
      clr_maps();
      scatter(1, hyst_cnt[k]);
      blank_noise(1);
      random_glove(0);
      run_frame("hyst");
      check($sformatf("hyst_%0d_closed", k), 32'(a_g2c), 32'(hyst_cl[k]));
    end

    // Seen at (30,30), then a 10-hit frame: unseen with position/grip held.
    clr_maps();
    rect(0, 20, 20, 21, 21);
    run_frame("present");
    sx = 32'(a_g1x); sy = 32'(a_g1y); sc = 32'(a_g1c);
    check("present_x", sx, 32'd30);
    clr_maps();
    scatter(0, 10);
    run_frame("absent");
    check("absent_seen", 32'(a_g1s), 32'd0);
    check("absent_x_hold", 32'(a_g1x), sx);
    check("absent_y_hold", 32'(a_g1y), sy);
    check("absent_closed_hold", 32'(a_g1c), sc);

    // Corner pixels plus a repeated column to reach MIN_PIXELS; blanking ignored.
    clr_maps();
    for (int v = 0; v < 16; v++) map[0][v][0] = 1'b1;
    map[0][VA - 1][HA - 1] = 1'b1;
    map[1][0][0] = 1'b1;
    map[1][VA - 1][HA - 1] = 1'b1;
    for (int v = 0; v < VT; v++)
      for (int h = HA; h < HT; h++) map[1][v][h] = 1'b1;
    run_frame("edges");
    check("edges_x", 32'(a_g1x), 32'(31));
    check("edges_y", 32'(a_g1y), 32'(23));
    check("edges_g2_seen", 32'(a_g2s), 32'd0);

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      clr_maps();
      random_glove(0);
      random_glove(1);
      run_frame("rand");
    end

    // Reset partway through a frame: outputs to reset values, no strobe
    // for the abandoned frame, next complete frame publishes normally.
    clr_maps();
    rect(0, 0, 0, 40, 40);
    rect(1, 5, 5, 30, 30);
    run_rows(0, 20, pa, ia, ps, is_);
    reset_b = 1'b0;
    @(posedge vclock);
    #1;
    model_reset();
    check("mrst_fd", 32'(a_fd), 32'd0);
    check_outputs("mrst");
    reset_b = 1'b1;
    run_rows(20, VT, pa, ia, ps, is_);
    check("mrst_no_pulse", 32'(pa), 32'd0);
    check("mrst_sat_no_pulse", 32'(ps), 32'd0);
    check("mrst_x_still_reset", 32'(a_g1x), 32'(HA / 2));
    clr_maps();
    random_glove(0);
    random_glove(1);
    run_frame("post_rst");

    // Every active pixel on glove 1; the 4-bit counter must stick at 15.
    clr_maps();
    rect(0, 0, 0, HA, VA);
    scatter(1, 8);
    run_frame("sat");
    check("sat_seen", 32'(s_g1s), 32'd1);
    check("sat_closed", 32'(s_g1c), 32'd0);
    check("sat_g2_closed", 32'(s_g2c), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
